// File: rtl/apb_mailbox_slave5.sv
// apb_mailbox_slave5: APB slave exposing a 32-bit mailbox FIFO with status, control, clear and a level interrupt.
module apb_mailbox_slave5 #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] RESET_WS = 2'd0
) (
  input  logic        pclk5,
  input  logic        n_preset5,
  input  logic        psel5,
  input  logic        penable5,
  input  logic        pwrite5,
  input  logic [4:0]  paddr5,
  input  logic [31:0] pwdata5,
  output logic [31:0] prdata5,
  output logic        pready5,
  output logic        pslverr5,
  output logic        irq5
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d, ws_q, ws_d;
  logic            irq_en_q, irq_en_d, ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     rdata;
  logic [2:0]      idx;
  logic            commit, empty, full, bad, err, is_data, push, pop, wr_ok, unused;
  assign unused  = ^{pwdata5[31:3], paddr5[1:0]};
  assign idx     = paddr5[4:2];
  assign empty   = count_q == '0;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign is_data = idx == 3'd0;
  assign commit  = state_q == ACCESS && psel5 && penable5 && wcnt_q == 2'd0;
  // Out-of-map offsets and STATUS writes are rejected before any side effect.
  assign bad     = paddr5[4] | (pwrite5 & idx == 3'd1);
  assign err     = bad | (is_data & (pwrite5 ? full : empty));
  assign wr_ok   = commit & pwrite5 & ~bad;
  assign push    = wr_ok & is_data & ~full;
  assign pop     = commit & ~pwrite5 & is_data & ~empty;
  assign rdata   = is_data      ? (empty ? 32'd0 : mem[rptr_q]) :
                   idx == 3'd1  ? {24'd0, udf_q, ovf_q, full, empty, 4'(count_q)} :
                   idx == 3'd2  ? {29'd0, irq_en_q, ws_q} : 32'd0;
  assign pready5  = commit;
  assign pslverr5 = commit & err;
  assign prdata5  = (commit & ~pwrite5) ? rdata : 32'd0;
  assign irq5     = irq_q;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (state_q == IDLE) begin
      if (psel5 && !penable5) begin
        state_d = ACCESS;
        wcnt_d  = ws_q;
      end
    end else if (!psel5) begin
      state_d = IDLE;
    end else if (penable5) begin
      if (wcnt_q != 2'd0) wcnt_d = wcnt_q - 2'd1;
      else state_d = IDLE;
    end
  end
  always_comb begin
    ws_d     = ws_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (wr_ok && is_data && full) ovf_d = 1'b1;
    if (commit && !pwrite5 && is_data && empty) udf_d = 1'b1;
    if (wr_ok && idx == 3'd2) begin
      ws_d     = pwdata5[1:0];
      irq_en_d = pwdata5[2];
    end
    if (wr_ok && idx == 3'd3) begin
      ovf_d = pwdata5[0] ? 1'b0 : ovf_d;
      udf_d = pwdata5[1] ? 1'b0 : udf_d;
      if (pwdata5[2]) begin
        wptr_d  = '0;
        rptr_d  = '0;
        count_d = '0;
      end
    end
    irq_d = irq_en_q & (~empty | ovf_q | udf_q);
  end
  always_ff @(posedge pclk5 or negedge n_preset5) begin
    if (!n_preset5) begin
      state_q  <= IDLE;
      wcnt_q   <= 2'd0;
      ws_q     <= RESET_WS;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ws_q     <= ws_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is not reset; pointers and count alone define FIFO state.
  always_ff @(posedge pclk5) begin
    if (push) mem[wptr_q] <= pwdata5;
  end
endmodule

// File: tb/tb_apb_mailbox_slave5.sv
// tb_apb_mailbox_slave5: directed and random APB traffic checked against a queue-based mailbox model.
module tb_apb_mailbox_slave5;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic        pready, pslverr, irq;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0, m_udf = 1'b0, m_ien = 1'b0;
  logic [1:0]  m_ws = 2'd0;

  apb_mailbox_slave5 #(.DEPTH(DEPTH), .RESET_WS(2'd0)) dut (
    .pclk5(clk), .n_preset5(rst_n), .psel5(psel), .penable5(penable), .pwrite5(pwrite),
    .paddr5(paddr), .pwdata5(pwdata), .prdata5(prdata), .pready5(pready),
    .pslverr5(pslverr), .irq5(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_irq();
    return m_ien & ((mq.size() != 0) | m_ovf | m_udf);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_ien = 1'b0; m_ws = 2'd0;
  endtask

  task automatic model(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int off = int'(addr) / 4;
    rd = 32'd0; er = 1'b0;
    if (off >= 4) er = 1'b1;
    else if (off == 0) begin
      if (wr) begin
        if (mq.size() == DEPTH) begin er = 1'b1; m_ovf = 1'b1; end
        else mq.push_back(wd);
      end else if (mq.size() == 0) begin er = 1'b1; m_udf = 1'b1; end
      else rd = mq.pop_front();
    end else if (off == 1) begin
      if (wr) er = 1'b1;
      else rd = mq.size() + ((mq.size() == 0) ? 16 : 0) + ((mq.size() == DEPTH) ? 32 : 0)
                + (m_ovf ? 64 : 0) + (m_udf ? 128 : 0);
    end else if (off == 2) begin
      if (wr) begin m_ws = wd[1:0]; m_ien = wd[2]; end
      else rd = {29'd0, m_ien, m_ws};
    end else if (wr) begin
      if (wd[0]) m_ovf = 1'b0;
      if (wd[1]) m_udf = 1'b0;
      if (wd[2]) mq.delete();
    end
  endtask

  task automatic xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd);
    logic [31:0] erd;
    logic        eer, old_irq;
    int          ew, waits;
    ew = int'(m_ws);
    old_irq = m_irq();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    #1 check("setup_pready", {31'd0, pready}, 32'd0);
    @(negedge clk);
    penable = 1'b1; waits = 0;
    #1;
    while (!pready && waits < 20) begin
      check("wait_prdata", prdata, 32'd0);
      check("wait_pslverr", {31'd0, pslverr}, 32'd0);
      @(negedge clk);
      #1 waits++;
    end
    check("pready_timeout", {31'd0, pready}, 32'd1);
    check("wait_states", 32'(waits), 32'(ew));
    model(wr, addr, wd, erd, eer);
    if (!wr) check("prdata", prdata, erd);
    check("pslverr", {31'd0, pslverr}, {31'd0, eer});
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1 check("irq_before", {31'd0, irq}, {31'd0, old_irq});
    @(negedge clk);
    #1 check("irq_after", {31'd0, irq}, {31'd0, m_irq()});
  endtask

  task automatic abort_psel(input logic [4:0] addr, input logic [31:0] wd);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    #1 check("abort_pready", {31'd0, pready}, 32'd0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2;
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b1, 5'h00, 32'h11111111);
    xfer(1'b1, 5'h00, 32'h22222222);
    xfer(1'b0, 5'h00, 32'h0);
    xfer(1'b0, 5'h00, 32'h0);
    xfer(1'b0, 5'h04, 32'h0);
    xfer(1'b1, 5'h08, 32'h3);
    xfer(1'b0, 5'h04, 32'h0);
    xfer(1'b1, 5'h08, 32'h0);
    for (int i = 0; i < 5; i++) xfer(1'b1, 5'h00, 32'hA0 + 32'(i));
    xfer(1'b0, 5'h04, 32'h0);
    for (int i = 0; i < 5; i++) xfer(1'b0, 5'h00, 32'h0);
    xfer(1'b0, 5'h04, 32'h0);
    xfer(1'b1, 5'h08, 32'h4);
    xfer(1'b1, 5'h00, 32'hCAFE0001);
    xfer(1'b1, 5'h0C, 32'h7);
    xfer(1'b0, 5'h04, 32'h0);
    xfer(1'b0, 5'h14, 32'h0);
    xfer(1'b1, 5'h04, 32'hFF);
    xfer(1'b1, 5'h08, 32'h5);
    abort_psel(5'h00, 32'hDEAD0000);
    xfer(1'b0, 5'h04, 32'h0);
    xfer(1'b1, 5'h08, 32'h6);
    xfer(1'b1, 5'h00, 32'hBEEF0001);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hBEEF0002;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pready", {31'd0, pready}, 32'd0);
    check("mid_rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("mid_rst_prdata", prdata, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 5'h04, 32'h0);
    xfer(1'b0, 5'h08, 32'h0);
    for (int i = 0; i < 400; i++) begin
      int          sel = int'($urandom_range(0, 11));
      logic [2:0]  off = (sel < 5) ? 3'd0 : 3'($urandom_range(1, 7));
      logic [4:0]  a = {off, 2'($urandom_range(0, 3))};
      logic        wr = 1'($urandom_range(0, 1));
      logic [31:0] wd = $urandom;
      if (off == 3'd3 && $urandom_range(0, 3) != 0) wd[2] = 1'b0;
      xfer(wr, a, wd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_mailbox_slave5.md
APB_MAILBOX_SLAVE5 -- requirements
Module: apb_mailbox_slave5

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of 32-bit mailbox FIFO entries and SHALL be a power of two from 2 to 8.
REQ-002 Parameter RESET_WS, default 0, sets the reset value of CTRL.ws (0-3).
REQ-003 Port pclk5, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port n_preset5, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port psel5, input, 1 bit: APB select.
REQ-006 Port penable5, input, 1 bit: APB access phase.
REQ-007 Port pwrite5, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port paddr5, input, 5 bits: byte offset; bits [1:0] are ignored.
REQ-009 Port pwdata5, input, 32 bits: write data.
REQ-010 Port prdata5, output, 32 bits: read data, valid only while pready5 = 1 on a read.
REQ-011 Port pready5, output, 1 bit: transfer completion.
REQ-012 Port pslverr5, output, 1 bit: error response, valid only while pready5 = 1.
REQ-013 Port irq5, output, 1 bit: level interrupt.

Function
REQ-014 Register map (word offsets):
- 0x00 DATA: a write pushes pwdata5; a read pops and returns the head entry.
- 0x04 STATUS (RO): [3:0] count, [4] empty, [5] full, [6] ovf (sticky), [7] udf (sticky), other bits 0.
- 0x08 CTRL (RW): [1:0] ws, [2] irq_en, other bits read 0.
- 0x0C CLEAR (WO, reads 0): [0] clears ovf, [1] clears udf, [2] flushes the FIFO.
REQ-015 The FSM SHALL have two states, IDLE and ACCESS.
- IDLE to ACCESS when psel5 = 1 and penable5 = 0; the wait counter wcnt loads CTRL.ws.
REQ-016 In ACCESS with psel5 & penable5 and wcnt != 0, wcnt SHALL decrement and pready5 SHALL be 0.
REQ-017 In ACCESS with psel5 & penable5 and wcnt = 0, pready5 SHALL be 1 combinationally.
- The register side effect SHALL commit on that clock edge, and the FSM returns to IDLE.
REQ-018 Transfer latency SHALL be ws + 1 access-phase cycles; with ws = 0 there are no wait states.
REQ-019 If psel5 deasserts while in ACCESS, the FSM SHALL return to IDLE with no side effect.
REQ-020 pready5 SHALL be 0 in IDLE.
- prdata5 and pslverr5 SHALL be 0 whenever pready5 = 0.
REQ-021 A change to CTRL.ws SHALL take effect from the next transfer.
REQ-022 A DATA write while full SHALL:
- drop the data;
- set ovf;
- assert pslverr5 on completion.
REQ-023 A DATA read while empty SHALL:
- return 0;
- set udf;
- assert pslverr5 on completion.
- Pointers and count SHALL be unchanged.
REQ-024 The following SHALL complete with pslverr5 = 1 and no side effect:
- any access to offset >= 0x10;
- a write to STATUS.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
- count SHALL range 0 to DEPTH and be log2(DEPTH)+1 bits wide.
REQ-026 A CLEAR write with bit 2 set SHALL zero the pointers and count in the commit cycle.
- Bits 0, 1 and 2 SHALL all act in the same cycle when set together.
- A flush SHALL not alter ovf or udf unless bits 0 or 1 are also set.
REQ-027 A sticky flag set and cleared in the same cycle is not possible, since only one transfer commits per cycle; no arbitration is required.
REQ-028 irq5 SHALL be registered, equal to irq_en & (!empty | ovf | udf), and update one cycle after the causing commit.

Reset
REQ-029 While n_preset5 = 0, all of the following SHALL hold immediately, independent of pclk5:
- FSM in IDLE, wcnt = 0;
- pointers = 0, count = 0, ovf = 0, udf = 0;
- CTRL.ws = RESET_WS, irq_en = 0;
- pready5 = 0, pslverr5 = 0, prdata5 = 0, irq5 = 0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no side effect.
- The first transfer after release SHALL start from a setup phase.
REQ-031 FIFO storage contents need no reset; only pointers and count define state.

Verification
REQ-032 Push/pop with ws = 0:
- Stimulus: write 0x11111111 then 0x22222222 to DATA, then read DATA twice.
- Required: each transfer completes with one access cycle; reads return 0x11111111 then 0x22222222; STATUS reads 0x00000010 afterwards.
REQ-033 Wait states:
- Stimulus: write CTRL = 0x3, then read STATUS.
- Required: pready5 stays low for 3 access cycles and is high on the 4th; prdata5 = 0x00000010.
REQ-034 Full and empty errors (DEPTH = 4):
- Stimulus: 5 writes to DATA.
- Required: the 5th completes with pslverr5 = 1 and STATUS = 0x00000064.
- Stimulus: 5 reads from DATA.
- Required: the 5th returns 0 with pslverr5 = 1; STATUS shows udf set.
REQ-035 Interrupt and clear:
- Stimulus: CTRL = 0x4, then one DATA write.
- Required: irq5 rises one cycle after the write commits.
- Stimulus: CLEAR = 0x7.
- Required: count = 0, ovf = 0, udf = 0, and irq5 falls on the next cycle.
REQ-036 Bad address and abort:
- Stimulus: read offset 0x14.
- Required: pslverr5 = 1, prdata5 = 0.
- Stimulus: a DATA write with ws = 2, with reset asserted in the 2nd access cycle.
- Required: count = 0 after release and all outputs 0 during reset.
